// File: rtl/booth_cs_accum_if.sv
// booth_cs_accum_if: operand/result handshake bundle for the radix-4 Booth carry-save multiplier
// master: drives in_valid, A, B, out_ready; slave: drives in_ready, out_valid, SumVec, CarryVec
interface booth_cs_accum_if #(parameter int N = 32);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] SumVec;
    logic [2*N-1:0] CarryVec;
    modport master(output in_valid, A, B, out_ready, input in_ready, out_valid, SumVec, CarryVec);
    modport slave(input in_valid, A, B, out_ready, output in_ready, out_valid, SumVec, CarryVec);
endinterface

// File: rtl/booth_cs_accum.sv
// booth_cs_accum: sequential radix-4 Booth multiplier leaving A*B in carry-save form (SumVec+CarryVec)
// clk, rst (async active-high); bus: in_valid/in_ready/A/B in, out_valid/out_ready/SumVec/CarryVec out
module booth_cs_accum #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_cs_accum_if.slave      bus
);
    localparam int CW = $clog2(N / 2) + 1;
    localparam logic [CW-1:0] LAST = CW'(N / 2 - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state_q;
    logic           in_ready_q, out_valid_q;
    logic [N-1:0]   a_q, b_q;
    logic [2*N-1:0] s_q, c_q, s_d, c_d;
    logic [CW-1:0]  cnt_q;
    logic [N:0]     b_ext;
    logic [2:0]     trip;
    logic [2*N-1:0] a_ext, mag, pp;
    always_comb begin
        // B[-1] = 0 appended below bit 0 so each digit is a 3-bit window at 2*cnt
        b_ext = {b_q, 1'b0};
        trip  = b_ext[{cnt_q, 1'b0} +: 3];
        a_ext = {{N{a_q[N-1]}}, a_q};
        mag   = (trip == 3'b000 || trip == 3'b111) ? '0 :
                (trip == 3'b011 || trip == 3'b100) ? a_ext << 1 : a_ext;
        pp    = (trip[2] ? -mag : mag) << {cnt_q, 1'b0};
        s_d   = s_q ^ c_q ^ pp;
        c_d   = ((s_q & c_q) | (s_q & pp) | (c_q & pp)) << 1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_q        <= bus.A;
                    b_q        <= bus.B;
                    s_q        <= '0;
                    c_q        <= '0;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
                    state_q    <= RUN;
                end
                RUN: begin
                    s_q   <= s_d;
                    c_q   <= c_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.SumVec    = s_q;
    assign bus.CarryVec  = c_q;
endmodule

// File: tb/tb_booth_cs_accum.sv
// tb_booth_cs_accum: directed and randomized checks of booth_cs_accum against a signed-product model
module tb_booth_cs_accum;
    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int fails = 0;
    logic [63:0] r;
    always #5 clk = ~clk;
    booth_cs_accum_if #(.N(32)) bus();
    booth_cs_accum #(.N(32)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // downstream 64-bit Kogge-Stone adder, Cin = 0
    function automatic logic [63:0] ks_add(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] g, p, p0, gn, pn;
        g = x & y;
        p = x ^ y;
        p0 = p;
        for (int d = 1; d < 64; d = d * 2) begin
            gn = g | (p & (g << d));
            pn = p & (p << d);
            g = gn;
            p = pn;
        end
        return p0 ^ (g << 1);
    endfunction
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall, output logic [63:0] sum);
        logic [63:0] exp, sv, cv;
        int w, lat;
        exp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        bus.A = $urandom;
        bus.B = $urandom;
        check("in_ready_busy", 64'(bus.in_ready), 64'd0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            bus.A = $urandom;
            bus.B = $urandom;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b0;
        check("latency", 64'(lat), 64'd16);
        sv = bus.SumVec;
        cv = bus.CarryVec;
        sum = ks_add(sv, cv);
        check("product", sum, exp);
        repeat (stall) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.A = $urandom;
            bus.B = $urandom;
            @(negedge clk);
            check("stall_sum", bus.SumVec, sv);
            check("stall_carry", bus.CarryVec, cv);
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("release_valid", 64'(bus.out_valid), 64'd0);
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
    endtask
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction
    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum", bus.SumVec, 64'd0);
        check("rst_carry", bus.CarryVec, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd3, 32'd5, 0, r);
        check("3x5", r, 64'd15);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, r);
        check("m1xm1", r, 64'd1);
        run_op(32'h8000_0000, 32'h8000_0000, 2, r);
        check("minxmin", r, 64'h4000_0000_0000_0000);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 0, r);
        check("maxxmin", r, 64'hC000_0000_8000_0000);
        run_op(32'h1234_5679, 32'h9ABC_DEF3, 5, r);
        @(negedge clk);
        bus.A = 32'h1234_5679;
        bus.B = 32'h9ABC_DEF3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_sum", bus.SumVec, 64'd0);
        check("midrst_carry", bus.CarryVec, 64'd0);
        #1 rst = 1'b0;
        run_op(32'hFFFF_FFF9, 32'd9, 1, r);
        check("m7x9", r, 64'hFFFF_FFFF_FFFF_FFC1);
        for (int i = 0; i < 2000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(pick(), pick(), $urandom_range(0, 3), r);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
